// File: rtl/am25ls_scanmux.sv
// Registered N-channel word selector with direct select and auto-scan modes.
// Scan counter wraps at CHANNELS-1 so odd channel counts never go illegal.
module am25ls_scanmux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      g_n,
  input  logic                      mode,
  input  logic                      ld,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] c,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam logic [SELW:0]   NCH  = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic             r_wrap;

  logic             w_sel_ok;
  logic [SELW-1:0]  w_scan_idx;
  logic             w_last;
  logic [SELW-1:0]  w_next;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_word;

  assign w_sel_ok   = ({1'b0, sel} < NCH);
  // an out-of-range load restarts the scan at channel 0
  assign w_scan_idx = ld ? (w_sel_ok ? sel : '0) : r_cnt;
  assign w_last     = (w_scan_idx == LAST);
  assign w_next     = w_last ? '0 : w_scan_idx + SELW'(1);
  assign w_idx      = mode ? w_scan_idx : sel;

  // illegal indices match no channel and yield zero
  always_comb begin
    w_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_idx == SELW'(k)) w_word = c[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (g_n) begin
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (!mode) begin
      r_y     <= w_word;
      r_ch    <= sel;
      r_valid <= w_sel_ok;
      r_wrap  <= 1'b0;
    end else begin
      r_y     <= w_word;
      r_ch    <= w_scan_idx;
      r_valid <= 1'b1;
      r_wrap  <= w_last;
      r_cnt   <= w_next;
    end
  end

  assign y     = r_y;
  assign ch    = r_ch;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule
